// File: rtl/ltl_mon_pkg.sv
// Shared types for the LTL monitor symbol feeder: FSM states, FIFO entry
// layout and the trace symbol width.
package ltl_mon_pkg;

    localparam int SYM_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        STREAM,
        DRAIN,
        DONE
    } feeder_state_e;

    typedef struct packed {
        logic [SYM_W-1:0] sym;
        logic             last;
    } fifo_entry_t;

endpackage

// File: rtl/ltl_sym_fifo.sv
// Small circular buffer of trace symbols. DEPTH must be a power of two so the
// pointers wrap for free. push/pop are qualified internally against
// full/empty; head is the oldest entry and is only meaningful when !empty.
module ltl_sym_fifo
    import ltl_mon_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  fifo_entry_t wdata,
    input  logic        pop,
    output fifo_entry_t head,
    output logic        full,
    output logic        empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    fifo_entry_t      mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage array; no reset needed because count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // Pointers and occupancy; reset flushes the buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ltl_symbol_feeder.sv
// Producer side of the LTL monitor symbol interface. Buffers trace symbols,
// sequences the automaton reset at each session start, streams symbols with
// run, and attributes automaton reports to the symbol index that caused them.
// Optional: define LTL_FEEDER_IDLE_FILL_EN to inject IDLE_SYM whenever the
// FIFO runs dry in STREAM, so automaton time keeps advancing.
module ltl_symbol_feeder
    import ltl_mon_pkg::*;
#(
    parameter int               DEPTH        = 4,
    parameter int               RESET_CYCLES = 2,
    parameter int               NUM_REP      = 4,
    parameter int               CNT_W        = 16,
    parameter logic [SYM_W-1:0] IDLE_SYM     = 8'd0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SYM_W-1:0]   in_symbol,
    input  logic               in_last,
    output logic [SYM_W-1:0]   sym_out,
    output logic               run_out,
    output logic               am_reset,
    input  logic [NUM_REP-1:0] report_in,
    output logic [NUM_REP-1:0] report_sticky,
    output logic               first_valid,
    output logic [CNT_W-1:0]   first_idx,
    output logic [CNT_W-1:0]   sym_count,
    output logic               done
);

    localparam int ARM_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    feeder_state_e    state;
    feeder_state_e    state_nxt;
    logic [ARM_W-1:0] arm_cnt;
    logic             arm_start;
    logic [SYM_W-1:0] sym_q;
    logic             run_d;
    logic [CNT_W-1:0] idx_d;

    fifo_entry_t      fifo_wdata;
    fifo_entry_t      fifo_head;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;

    // The automaton also sees the global reset, not just the ARM window.
    assign am_reset   = reset || (state == ARM);
    assign fifo_push  = in_valid && in_ready;
    assign fifo_wdata = '{sym: in_symbol, last: in_last};

    ltl_sym_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next-state and handshake/issue decode; reset masks everything so no
    // symbol is accepted or issued in a reset cycle.
    always_comb begin
        state_nxt = state;
        arm_start = 1'b0;
        in_ready  = 1'b0;
        run_out   = 1'b0;
        sym_out   = sym_q;
        fifo_pop  = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) begin
                    state_nxt = ARM;
                    arm_start = 1'b1;
                end
            end
            ARM: begin
                in_ready = !fifo_full;
                if (arm_cnt == '0) state_nxt = STREAM;
            end
            STREAM: begin
                in_ready = !fifo_full;
                if (!fifo_empty) begin
                    run_out  = 1'b1;
                    sym_out  = fifo_head.sym;
                    fifo_pop = 1'b1;
                    if (fifo_head.last) state_nxt = DRAIN;
                end else begin
`ifdef LTL_FEEDER_IDLE_FILL_EN
                    run_out = 1'b1;
                    sym_out = IDLE_SYM;
`else
                    run_out = 1'b0;
`endif
                end
            end
            DRAIN: state_nxt = DONE;
            DONE: begin
                done = 1'b1;
                if (frame_start) begin
                    state_nxt = ARM;
                    arm_start = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (reset) begin
            state_nxt = IDLE;
            arm_start = 1'b0;
            in_ready  = 1'b0;
            run_out   = 1'b0;
            sym_out   = sym_q;
            fifo_pop  = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // ARM down-counter: loaded on entry, ARM ends on the cycle it reads zero.
    always_ff @(posedge clk) begin
        if (reset)                           arm_cnt <= '0;
        else if (arm_start)                  arm_cnt <= ARM_W'(RESET_CYCLES - 1);
        else if (state == ARM && arm_cnt != '0) arm_cnt <= arm_cnt - ARM_W'(1);
    end

    // Last issued symbol, held on sym_out while the automaton is stalled.
    always_ff @(posedge clk) begin
        if (reset)        sym_q <= '0;
        else if (run_out) sym_q <= sym_out;
    end

    // Symbol counting and report attribution; a report seen one cycle after
    // a run cycle belongs to the index issued in that run cycle (idx_d).
    always_ff @(posedge clk) begin
        if (reset || arm_start) begin
            run_d         <= 1'b0;
            idx_d         <= '0;
            sym_count     <= '0;
            report_sticky <= '0;
            first_valid   <= 1'b0;
            first_idx     <= '0;
        end else begin
            run_d <= run_out;
            idx_d <= sym_count;
            if (run_out && sym_count != '1) sym_count <= sym_count + CNT_W'(1);
            if (run_d && |report_in) begin
                report_sticky <= report_sticky | report_in;
                if (!first_valid) begin
                    first_valid <= 1'b1;
                    first_idx   <= idx_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_ltl_symbol_feeder.sv
// Directed bench for ltl_symbol_feeder: reset values, basic session, report
// attribution, stall (with/without LTL_FEEDER_IDLE_FILL_EN), reset mid-stream,
// frame_start handling, and backpressure on a second instance with a long ARM.
module tb_ltl_symbol_feeder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_symbol = 8'h00;
    logic        in_last = 1'b0;
    logic [7:0]  sym_out;
    logic        run_out;
    logic        am_reset;
    logic [3:0]  report_in = 4'h0;
    logic [3:0]  report_sticky;
    logic        first_valid;
    logic [15:0] first_idx;
    logic [15:0] sym_count;
    logic        done;

    logic        b_frame_start = 1'b0;
    logic        b_in_valid = 1'b0;
    logic        b_in_ready;
    logic [7:0]  b_in_symbol = 8'h00;
    logic        b_in_last = 1'b0;
    logic [7:0]  b_sym_out;
    logic        b_run_out;
    logic        b_am_reset;
    logic [3:0]  b_report_sticky;
    logic        b_first_valid;
    logic [15:0] b_first_idx;
    logic [15:0] b_sym_count;
    logic        b_done;

    int checks = 0;
    int failures = 0;

`ifdef LTL_FEEDER_IDLE_FILL_EN
    localparam bit FILL = 1'b1;
`else
    localparam bit FILL = 1'b0;
`endif

    always #5 clk = ~clk;

    ltl_symbol_feeder dut (
        .clk(clk), .reset(reset), .frame_start(frame_start),
        .in_valid(in_valid), .in_ready(in_ready), .in_symbol(in_symbol),
        .in_last(in_last), .sym_out(sym_out), .run_out(run_out),
        .am_reset(am_reset), .report_in(report_in),
        .report_sticky(report_sticky), .first_valid(first_valid),
        .first_idx(first_idx), .sym_count(sym_count), .done(done)
    );

    ltl_symbol_feeder #(.RESET_CYCLES(6)) u_bp (
        .clk(clk), .reset(reset), .frame_start(b_frame_start),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_symbol(b_in_symbol),
        .in_last(b_in_last), .sym_out(b_sym_out), .run_out(b_run_out),
        .am_reset(b_am_reset), .report_in(4'h0),
        .report_sticky(b_report_sticky), .first_valid(b_first_valid),
        .first_idx(b_first_idx), .sym_count(b_sym_count), .done(b_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] s, input logic l);
        in_valid  = 1'b1;
        in_symbol = s;
        in_last   = l;
    endtask

    initial begin
        logic [7:0] got [8];
        int sent;
        int n;
        int acc_at_drop;

        // ---------------- reset values
        tick(); tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_run_out", run_out, 0);
        check("rst_sym_out", sym_out, 0);
        check("rst_am_reset", am_reset, 1);
        check("rst_sticky", report_sticky, 0);
        check("rst_first_valid", first_valid, 0);
        check("rst_first_idx", first_idx, 0);
        check("rst_sym_count", sym_count, 0);
        check("rst_done", done, 0);
        reset = 1'b0;
        #1;
        check("idle_am_reset", am_reset, 0);
        check("idle_in_ready", in_ready, 0);

        // ---------------- basic session + report attribution
        frame_start = 1'b1;
        tick();                                    // ARM1
        frame_start = 1'b0;
        check("arm1_am_reset", am_reset, 1);
        check("arm1_in_ready", in_ready, 1);
        check("arm1_run_out", run_out, 0);
        push(8'h02, 1'b0);
        tick();                                    // ARM2
        check("arm2_am_reset", am_reset, 1);
        push(8'h05, 1'b0);
        tick();                                    // STREAM1
        check("s1_am_reset", am_reset, 0);
        check("s1_run_out", run_out, 1);
        check("s1_sym_out", sym_out, 8'h02);
        push(8'h0A, 1'b1);
        tick();                                    // STREAM2
        in_valid = 1'b0;
        check("s2_run_out", run_out, 1);
        check("s2_sym_out", sym_out, 8'h05);
        check("s2_sym_count", sym_count, 1);
        tick();                                    // STREAM3
        check("s3_run_out", run_out, 1);
        check("s3_sym_out", sym_out, 8'h0A);
        check("s3_sym_count", sym_count, 2);
        report_in = 4'b0010;                       // caused by index 1
        tick();                                    // DRAIN
        check("drain_first_valid", first_valid, 1);
        check("drain_first_idx", first_idx, 1);
        check("drain_sticky", report_sticky, 4'b0010);
        check("drain_sym_count", sym_count, 3);
        check("drain_run_out", run_out, 0);
        check("drain_in_ready", in_ready, 0);
        check("drain_done", done, 0);
        report_in = 4'b1000;                       // caused by index 2
        tick();                                    // DONE
        report_in = 4'b0000;
        check("done_done", done, 1);
        check("done_sticky", report_sticky, 4'b1010);
        check("done_first_idx", first_idx, 1);
        check("done_in_ready", in_ready, 0);
        report_in = 4'b0001;                       // ignored: run_d=0
        tick();
        report_in = 4'b0000;
        check("done_ignore_rep", report_sticky, 4'b1010);

        // ---------------- frame_start in DONE -> ARM, stall test
        frame_start = 1'b1;
        tick();                                    // ARM1
        frame_start = 1'b0;
        check("rearm_am_reset", am_reset, 1);
        check("rearm_sticky", report_sticky, 0);
        check("rearm_first_valid", first_valid, 0);
        check("rearm_sym_count", sym_count, 0);
        check("rearm_done", done, 0);
        push(8'h11, 1'b0);
        tick();                                    // ARM2
        in_valid = 1'b0;
        tick();                                    // STREAM1
        check("st1_sym_out", sym_out, 8'h11);
        for (int g = 0; g < 3; g++) begin          // STREAM2..4 empty
            tick();
            check("gap_run_out", run_out, FILL ? 1 : 0);
            check("gap_sym_out", sym_out, FILL ? 8'h00 : 8'h11);
        end
        push(8'h22, 1'b1);
        tick();                                    // STREAM5
        in_valid = 1'b0;
        check("st5_run_out", run_out, 1);
        check("st5_sym_out", sym_out, 8'h22);
        check("st5_sym_count", sym_count, FILL ? 4 : 1);
        tick();                                    // DRAIN
        check("st_drain_count", sym_count, FILL ? 5 : 2);
        tick();                                    // DONE
        check("st_done", done, 1);

        // ---------------- frame_start in STREAM ignored, reset mid-stream
        frame_start = 1'b1;
        tick();                                    // ARM1
        frame_start = 1'b0;
        push(8'h31, 1'b0);
        tick();                                    // ARM2
        push(8'h32, 1'b0);
        tick();                                    // STREAM1
        check("rs1_sym_out", sym_out, 8'h31);
        push(8'h33, 1'b0);
        tick();                                    // STREAM2
        check("rs2_sym_out", sym_out, 8'h32);
        push(8'h34, 1'b0);
        frame_start = 1'b1;
        tick();                                    // STREAM3 (frame_start ignored)
        frame_start = 1'b0;
        in_valid = 1'b0;
        check("fs_ignored_am_reset", am_reset, 0);
        check("fs_ignored_run_out", run_out, 1);
        check("fs_ignored_sym_out", sym_out, 8'h33);
        reset = 1'b1;
        tick();
        check("mid_rst_run_out", run_out, 0);
        check("mid_rst_sym_out", sym_out, 0);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_am_reset", am_reset, 1);
        check("mid_rst_sym_count", sym_count, 0);
        check("mid_rst_done", done, 0);
        reset = 1'b0;
        #1;
        check("post_rst_am_reset", am_reset, 0);
        check("post_rst_in_ready", in_ready, 0);
        frame_start = 1'b1;
        tick();                                    // ARM1
        frame_start = 1'b0;
        check("restart_count", sym_count, 0);
        check("restart_am_reset", am_reset, 1);
        tick();                                    // ARM2
        tick();                                    // STREAM1, FIFO must be empty
        check("flushed_run_out", run_out, FILL ? 1 : 0);
        check("flushed_sym_out", sym_out, 8'h00);
        push(8'h41, 1'b1);
        tick();                                    // STREAM2
        in_valid = 1'b0;
        check("r_s2_sym_out", sym_out, 8'h41);
        check("r_s2_run_out", run_out, 1);
        check("r_s2_count", sym_count, FILL ? 1 : 0);
        tick();                                    // DRAIN
        tick();                                    // DONE
        check("r_done", done, 1);
        check("r_final_count", sym_count, FILL ? 2 : 1);

        // ---------------- backpressure on the long-ARM instance
        b_frame_start = 1'b1;
        tick();
        b_frame_start = 1'b0;
        sent = 0;
        n = 0;
        acc_at_drop = -1;
        for (int c = 0; c < 60 && !b_done; c++) begin
            b_in_valid  = (sent < 6);
            b_in_symbol = 8'h50 + sent[7:0];
            b_in_last   = (sent == 5);
            #1;
            if (b_run_out && n < 8) begin
                got[n] = b_sym_out;
                n++;
            end
            if (!b_in_ready && acc_at_drop < 0) acc_at_drop = sent;
            if (b_in_valid && b_in_ready) sent++;
            tick();
        end
        b_in_valid = 1'b0;
        check("bp_done_reached", b_done, 1);
        check("bp_accepts_at_drop", acc_at_drop, 4);
        check("bp_delivered", n, 6);
        for (int i = 0; i < 6; i++)
            check("bp_order", (i < n) ? got[i] : 8'hxx, 8'h50 + i[7:0]);
        check("bp_sym_count", b_sym_count, 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ltl_symbol_feeder.md
Name: ltl_symbol_feeder

Overview:
- Producer end of the LTL monitor symbol interface. Accepts encoded 8-bit trace symbols from the core trace tap over a valid/ready handshake and buffers them in a small FIFO.
- Drives the automaton's symbols/run/reset inputs, with correct reset sequencing so the automaton's start_of_data fires on each new trace session.
- Collects the automaton's report outputs and records which symbol index first triggered a report.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- RESET_CYCLES, 2, cycles am_reset is held at session start; at least 1.
- NUM_REP, 4, number of automaton report lines.
- CNT_W, 16, symbol index counter width.
- IDLE_SYM, 8'd0, symbol injected by the optional feature.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- frame_start  in  1  one-cycle pulse; begins a new trace session
- in_valid  in  1  trace symbol valid
- in_ready  out  1  feeder can accept
- in_symbol  in  8  encoded trace symbol
- in_last  in  1  final symbol of the session
- sym_out  out  8  to automaton symbols
- run_out  out  1  to automaton run
- am_reset  out  1  to automaton reset
- report_in  in  NUM_REP  automaton report outputs
- report_sticky  out  NUM_REP  OR of all reports this session
- first_valid  out  1  at least one report seen
- first_idx  out  CNT_W  index of the symbol that caused the first report
- sym_count  out  CNT_W  symbols issued this session
- done  out  1  session complete

Behaviour:

Clocking and reset:
- Clock clk; reset is synchronous, active-high.
- On reset: FSM goes to IDLE and the FIFO is flushed.
- Reset values: in_ready=0, run_out=0, sym_out=0, am_reset=1, report_sticky=0, first_valid=0, first_idx=0, sym_count=0, done=0.

Automaton reset:
- am_reset = reset OR (state==ARM). It is driven combinationally so the automaton also sees the global reset.

States:
- IDLE: run_out=0 and in_ready=0. frame_start moves to ARM.
- ARM: am_reset=1 for exactly RESET_CYCLES cycles (down-counter). On entry, clears sticky, first_*, sym_count and done. in_ready=!full, so the FIFO may prefill. After the last ARM cycle, moves to STREAM.
- STREAM:
  - FIFO non-empty: run_out=1, sym_out=head, pop, sym_count++.
  - Popped entry has last=1: move to DRAIN.
  - FIFO empty: run_out=0, and sym_out holds its previous value.
- DRAIN: one cycle that samples the report caused by the final symbol. in_ready=0. Then moves to DONE.
- DONE: done=1 and in_ready=0. frame_start moves to ARM. All other inputs are ignored.

frame_start handling:
- Ignored in ARM, STREAM and DRAIN.

FIFO:
- Each entry is {symbol, last}.
- Push when in_valid && in_ready.
- There is no bypass: a symbol accepted in cycle t drives run_out at t+1 at the earliest.
- Push and pop in the same cycle are legal whenever in_ready=1.
- in_ready deasserts combinationally when the occupancy count == DEPTH.
- Read and write pointers wrap modulo DEPTH.

Report attribution:
- The automaton registers its state on the clock edge at the end of a run cycle. report_in valid in cycle t+1 belongs to the symbol issued in cycle t.
- The feeder keeps a one-cycle run_d delay and an index register idx_d.
- When run_d=1 and |report_in:
  - report_sticky |= report_in.
  - If first_valid==0: set first_valid=1 and first_idx=idx_d.
- report_in is ignored when run_d=0.

Counting:
- sym_count saturates at all-ones and does not wrap.
- Indexing is 0-based: the first symbol of a session is index 0.

Boundary conditions:
- in_last on the first symbol: STREAM lasts one run cycle, then DRAIN.
- in_valid while in IDLE or DONE: not accepted (in_ready=0).
- reset mid-STREAM: FIFO is flushed and the FSM returns to IDLE.

Optional Feature:
- Macro: LTL_FEEDER_IDLE_FILL_EN.
- When defined: in STREAM with an empty FIFO, run_out=1 and sym_out=IDLE_SYM, so automaton time keeps advancing. Injected symbols increment sym_count and count for report attribution.
- When undefined: an empty FIFO stalls the automaton (run_out=0), as described in Behaviour.

Decomposition:
- Shared package ltl_mon_pkg holds:
  - typedef feeder_state_e {IDLE, ARM, STREAM, DRAIN, DONE};
  - typedef fifo_entry_t {logic [7:0] sym; logic last;};
  - localparam SYM_W=8.
- Sub-module ltl_sym_fifo: parameterised DEPTH circular buffer exposing push, pop, full, empty and head. The FSM and report logic stay in the top module.

Test Plan:
- Basic session: frame_start, then push 8'h02, 8'h05, 8'h0A(last) back-to-back -> am_reset high for 2 cycles; run_out high for 3 cycles with sym_out 02, 05, 0A; done=1 one cycle after DRAIN; sym_count=3.
- Report attribution: report_in=4'b0010 on the cycle after symbol index 1 -> first_valid=1, first_idx=1, report_sticky=4'b0010. A later report 4'b1000 -> sticky=4'b1010 and first_idx stays 1.
- Backpressure: hold in_valid with 6 symbols during ARM -> in_ready drops after 4 accepts; all 6 delivered in order with none lost or duplicated.
- Stall: gap of 3 cycles between pushes in STREAM -> run_out=0 during the gap and sym_out held. With LTL_FEEDER_IDLE_FILL_EN: run_out=1, sym_out=8'd0 and sym_count grows by 3.
- Reset mid-stream: assert reset after 2 of 5 symbols -> next cycle all outputs at reset values and FIFO empty. A new frame_start restarts with sym_count=0.
- frame_start in STREAM is ignored; frame_start in DONE -> ARM, sticky and first_valid cleared.
